// File: rtl/pipeline_if.sv
// Instruction-fetch stage: fetches 32-bit words from instruction memory into a
// halfword prefetch FIFO and presents the next 32-bit instruction window
// {hw1,hw0} to decode. Decode pops one (RVC) or two halfwords per cycle and
// can redirect the stream at any time; a redirect flushes the FIFO, drops the
// response that belongs to the old stream and fetches the new target at once.
// Optional build macro IF_PERF_CNT_EN adds starvation and redirect counters.

// Protocol checker for the fetch stage, kept apart from the datapath.
module pipeline_if_chk (
    input logic i_clk,
    input logic i_rst_n,
    input logic i_rvalid,
    input logic i_inflight,
    input logic i_taken,
    input logic i_redir_lsb
);
    // A memory response must always match an outstanding request.
    a_rvalid_has_req: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_rvalid |-> i_inflight);

    // Redirect targets are halfword aligned.
    a_redir_aligned: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_taken |-> !i_redir_lsb);
endmodule

module pipeline_if #(
    parameter int unsigned DEPTH_HW  = 8,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        taken_d_i,
    input  logic [31:0] redirection_d_i,
    input  logic        is_compressed_d_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instruction_f_o,
    output logic        instr_valid_f_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_starve_cnt_o,
    output logic [31:0] perf_redirect_cnt_o
`endif
);
    localparam int unsigned PW = $clog2(DEPTH_HW);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0]   ISSUE_LIMIT = (CW+1)'(DEPTH_HW - 32'd2);
    localparam logic [CW-1:0] CNT_ONE     = CW'(32'd1);
    localparam logic [CW-1:0] CNT_TWO     = CW'(32'd2);
    localparam logic [PW-1:0] PTR_ONE     = PW'(32'd1);

    // Prefetch FIFO and fetch-side state.
    logic [15:0]   r_fifo [DEPTH_HW];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [31:0]   r_fetch_pc;
    logic          r_inflight;
    logic          r_skip_hw;

    logic [15:0]   w_hw0;
    logic [15:0]   w_hw1;
    logic          w_valid;
    logic [CW:0]   w_occ;
    logic          w_room;
    logic [31:0]   w_redir_word;
    logic          w_rsp;
    logic [1:0]    w_wr_n;
    logic          w_pop_req;
    logic [1:0]    w_pop_n;

    assign w_hw0        = r_fifo[r_head];
    assign w_hw1        = (r_count >= CNT_TWO) ? r_fifo[r_head + PTR_ONE] : 16'h0000;
    assign w_valid      = (r_count >= CNT_TWO) | ((r_count == CNT_ONE) & (w_hw0[1:0] != 2'b11));

    // Halfwords already buffered plus those still on their way from memory.
    assign w_occ        = {1'b0, r_count} + {{(CW-1){1'b0}}, r_inflight, 1'b0};
    assign w_room       = (w_occ <= ISSUE_LIMIT);
    assign w_redir_word = {redirection_d_i[31:2], 2'b00};

    // A response in the redirect cycle belongs to the abandoned stream.
    assign w_rsp        = imem_rvalid_i & ~taken_d_i & r_inflight;
    assign w_pop_req    = enable & w_valid & ~taken_d_i;

    assign instr_valid_f_o = w_valid;
    assign instruction_f_o = w_valid ? {w_hw1, w_hw0} : NOP_INSTR;
    assign imem_req_o      = resetn & (taken_d_i | w_room);
    assign imem_addr_o     = taken_d_i ? w_redir_word : r_fetch_pc;

    // Number of halfwords a response deposits: the first one is skipped after an odd redirect.
    always_comb begin
        w_wr_n = 2'd0;
        if (w_rsp) begin
            w_wr_n = r_skip_hw ? 2'd1 : 2'd2;
        end else begin
            w_wr_n = 2'd0;
        end
    end

    // Number of halfwords decode consumes, never more than what is buffered.
    always_comb begin
        w_pop_n = 2'd0;
        if (!w_pop_req) begin
            w_pop_n = 2'd0;
        end else if (is_compressed_d_i | (r_count == CNT_ONE)) begin
            w_pop_n = 2'd1;
        end else begin
            w_pop_n = 2'd2;
        end
    end

    // FIFO storage: little-endian halfwords of each response land at the tail.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH_HW); i++) begin
                r_fifo[i] <= 16'h0000;
            end
        end else if (w_rsp) begin
            if (r_skip_hw) begin
                r_fifo[r_tail] <= imem_rdata_i[31:16];
            end else begin
                r_fifo[r_tail]           <= imem_rdata_i[15:0];
                r_fifo[r_tail + PTR_ONE] <= imem_rdata_i[31:16];
            end
        end
    end

    // Pointers, occupancy and fetch address; a redirect overrides everything else.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_fetch_pc <= RESET_PC;
            r_inflight <= 1'b0;
            r_skip_hw  <= 1'b0;
        end else if (taken_d_i) begin
            r_head     <= r_tail;
            r_count    <= '0;
            r_fetch_pc <= w_redir_word + 32'd4;
            r_inflight <= 1'b1;
            r_skip_hw  <= redirection_d_i[1];
        end else begin
            r_head     <= r_head + PW'(w_pop_n);
            r_tail     <= r_tail + PW'(w_wr_n);
            r_count    <= r_count + CW'(w_wr_n) - CW'(w_pop_n);
            r_inflight <= w_room;
            if (w_room) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_rsp) begin
                r_skip_hw <= 1'b0;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_starve_cnt;
    logic [31:0] r_redirect_cnt;

    // Count cycles where decode wanted an instruction but none was ready, and redirects.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_starve_cnt   <= 32'd0;
            r_redirect_cnt <= 32'd0;
        end else begin
            if (enable & ~w_valid & ~taken_d_i) begin
                r_starve_cnt <= r_starve_cnt + 32'd1;
            end
            if (taken_d_i) begin
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            end
        end
    end

    assign perf_starve_cnt_o   = r_starve_cnt;
    assign perf_redirect_cnt_o = r_redirect_cnt;
`endif

    pipeline_if_chk u_chk (
        .i_clk       (clk),
        .i_rst_n     (resetn),
        .i_rvalid    (imem_rvalid_i),
        .i_inflight  (r_inflight),
        .i_taken     (taken_d_i),
        .i_redir_lsb (redirection_d_i[0])
    );
endmodule

// File: tb/tb_pipeline_if.sv
// Bench for pipeline_if: an instruction memory that answers one cycle after
// each request, and a queue-based model of the instruction stream that
// predicts request, address, valid and instruction every cycle.
module tb_pipeline_if;
    localparam int          DEPTH = 8;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        taken = 1'b0;
    logic [31:0] redir = 32'd0;
    logic        comp = 1'b0;
    logic        req;
    logic [31:0] addr;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic [31:0] instr;
    logic        valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_starve;
    logic [31:0] perf_redirect;
`endif

    always #5 clk = ~clk;

    pipeline_if dut (
        .clk               (clk),
        .resetn            (resetn),
        .enable            (enable),
        .taken_d_i         (taken),
        .redirection_d_i   (redir),
        .is_compressed_d_i (comp),
        .imem_req_o        (req),
        .imem_addr_o       (addr),
        .imem_rvalid_i     (rvalid),
        .imem_rdata_i      (rdata),
        .instruction_f_o   (instr),
        .instr_valid_f_o   (valid)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_starve_cnt_o   (perf_starve),
        .perf_redirect_cnt_o (perf_redirect)
`endif
    );

    // Instruction memory: 512 bytes, aliased over the whole address space.
    logic [31:0] mem [128];
    always @(posedge clk) begin
        rvalid <= req;
        rdata  <= mem[addr[8:2]];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the program-order halfword stream visible to decode.
    logic [15:0] hw_q [$];
    logic [31:0] m_pc;
    bit          m_skip;
    bit          m_pend;
    logic [31:0] m_pend_word;
    bit          exp_req;
    bit          exp_valid;
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    logic        s_req;
    logic        s_valid;
    logic [31:0] s_addr;
    logic [31:0] s_instr;

    task automatic model_reset();
        hw_q.delete();
        m_pc   = RPC;
        m_skip = 1'b0;
        m_pend = 1'b0;
    endtask

    task automatic step(input bit en, input bit tk, input logic [31:0] rd, input bit cp, input bit rn);
        int n;
        int k;
        @(negedge clk);
        resetn = rn;
        enable = en;
        taken  = tk;
        redir  = rd;
        comp   = cp;
        #1;
        n = hw_q.size();
        if (!rn) begin
            exp_req   = 1'b0;
            exp_valid = 1'b0;
            exp_instr = NOP;
            exp_addr  = RPC;
        end else begin
            exp_valid = (n >= 2) || (n == 1 && hw_q[0][1:0] != 2'b11);
            exp_instr = !exp_valid ? NOP : {(n >= 2) ? hw_q[1] : 16'h0000, hw_q[0]};
            exp_req   = tk ? 1'b1 : (n + 2 * int'(m_pend) <= DEPTH - 2);
            exp_addr  = tk ? {rd[31:2], 2'b00} : m_pc;
        end
        s_req = req; s_valid = valid; s_addr = addr; s_instr = instr;
        check("req", {31'd0, s_req}, {31'd0, exp_req});
        check("valid", {31'd0, s_valid}, {31'd0, exp_valid});
        check("instr", s_instr, exp_instr);
        if (rn) check("addr", s_addr, exp_addr);
        @(posedge clk);
        if (!rn) begin
            model_reset();
        end else if (tk) begin
            hw_q.delete();
            m_pc        = {rd[31:2], 2'b00} + 32'd4;
            m_skip      = rd[1];
            m_pend      = 1'b1;
            m_pend_word = mem[rd[8:2]];
        end else begin
            if (en && exp_valid) begin
                k = cp ? 1 : 2;
                if (k > n) k = n;
                repeat (k) void'(hw_q.pop_front());
            end
            if (m_pend) begin
                if (m_skip) begin
                    hw_q.push_back(m_pend_word[31:16]);
                    m_skip = 1'b0;
                end else begin
                    hw_q.push_back(m_pend_word[15:0]);
                    hw_q.push_back(m_pend_word[31:16]);
                end
            end
            m_pend = exp_req;
            if (exp_req) begin
                m_pend_word = mem[m_pc[8:2]];
                m_pc        = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        logic [31:0] r;
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        mem[0] = 32'h00a0_0093;
        model_reset();

        // Held in reset.
        repeat (3) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        check("rst_req", {31'd0, s_req}, 32'd0);
        check("rst_valid", {31'd0, s_valid}, 32'd0);
        check("rst_instr", s_instr, NOP);

        // Release: request at RESET_PC in cycle 0, addi visible in cycle 2.
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        check("c0_req", {31'd0, s_req}, 32'd1);
        check("c0_addr", s_addr, 32'h0000_0000);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        check("c2_valid", {31'd0, s_valid}, 32'd1);
        check("c2_instr", s_instr, 32'h00a0_0093);
        repeat (3) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);

        // Two RVC instructions in one word, popped one per cycle.
        mem[0] = 32'h0001_4505;
        step(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
        check("rvc0", {16'd0, s_instr[15:0]}, 32'h0000_4505);
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
        check("rvc1", {16'd0, s_instr[15:0]}, 32'h0000_0001);
        check("rvc1_valid", {31'd0, s_valid}, 32'd1);

        // 32-bit instruction at 0x2 straddling words 0x0 and 0x4.
        mem[0] = 32'h0093_1234;
        mem[1] = 32'h5678_00a0;
        step(1'b0, 1'b1, 32'h0000_0002, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        check("straddle_wait", {31'd0, s_valid}, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        check("straddle_valid", {31'd0, s_valid}, 32'd1);
        check("straddle_instr", s_instr, 32'h00a0_0093);

        // Back-to-back redirects: the second one sees a stale response.
        mem[64] = 32'h4505_1111;
        step(1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0102, 1'b0, 1'b1);
        check("redir_addr", s_addr, 32'h0000_0100);
        check("redir_req", {31'd0, s_req}, 32'd1);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        check("redir_hi_only", s_instr, 32'h0000_4505);

        // Decode stalled: requests stop once the FIFO fills to 8 halfwords.
        step(1'b0, 1'b1, 32'h0000_0080, 1'b0, 1'b1);
        repeat (10) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        check("stall_req", {31'd0, s_req}, 32'd0);
        check("stall_valid", {31'd0, s_valid}, 32'd1);

        // Randomized traffic with a reset in the middle.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
                check("mid_rst_req", {31'd0, s_req}, 32'd0);
                check("mid_rst_valid", {31'd0, s_valid}, 32'd0);
                check("mid_rst_instr", s_instr, NOP);
                step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
                step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
                check("post_rst_addr", s_addr, RPC);
                check("post_rst_req", {31'd0, s_req}, 32'd1);
            end else begin
                r = $urandom;
                if ($urandom_range(0, 7) == 0) r = 32'hFFFF_FFF0 | (r & 32'h0000_000E);
                else r = r & 32'h0000_01FE;
                step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, r,
                     $urandom_range(0, 1) == 1, 1'b1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pipeline_if.md
Name: pipeline_if

Overview:
- Instruction-fetch stage, directly upstream of the decode stage.
- Fetches 32-bit words from instruction memory into a halfword prefetch FIFO.
- Presents the next 32-bit instruction window to decode, which may hold an RVC or a 32-bit instruction.
- Pops 1 or 2 halfwords per cycle according to decode's compressed flag; flushes and refetches on any decode-stage redirection.

Parameters:
- DEPTH_HW, 8, FIFO depth in 16-bit halfwords; power of 2, >=4.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, value driven on instruction_f_o when no valid instruction is available.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- enable  in  1  decode stage enabled; when 0, no pop occurs.
- taken_d_i  in  1  redirect request from decode.
- redirection_d_i  in  32  redirect target, halfword aligned.
- is_compressed_d_i  in  1  current instruction is 16-bit.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  word-aligned fetch address.
- imem_rvalid_i  in  1  response valid, exactly 1 cycle after req.
- imem_rdata_i  in  32  response word (little-endian halfwords).
- instruction_f_o  out  32  {hw1,hw0} at FIFO head.
- instr_valid_f_o  out  1  instruction_f_o holds a complete instruction.

Behaviour:
- Reset (async): count=0, head=tail=0, fetch_pc=RESET_PC, inflight=0, skip_hw=0.
  - imem_req_o=0, instr_valid_f_o=0, instruction_f_o=NOP_INSTR.
  - Reset asserted mid-operation discards all FIFO contents and in-flight responses.
- Valid rule: valid = (count>=2) | (count==1 & hw0[1:0]!=2'b11).
  - Valid: instruction_f_o={hw1,hw0}; when count==1, hw1 reads as 16'h0.
  - Not valid: instruction_f_o=NOP_INSTR.
- Pop: when enable & valid & ~taken_d_i, pop 1 halfword if is_compressed_d_i, else 2. Never pop more than count.
- Redirect (taken_d_i=1, cycle t): highest priority.
  - At edge t: count=0 and head=tail.
  - Any imem_rvalid_i in cycle t is dropped, since it belongs to the old stream.
  - In cycle t, combinationally: imem_req_o=1, imem_addr_o={redirection_d_i[31:2],2'b00}.
  - fetch_pc<=that address+4; skip_hw<=redirection_d_i[1]; inflight<=1.
  - Data is written at edge t+1 and is visible to decode in cycle t+2 (2-cycle redirect latency).
- Normal issue (no redirect): imem_req_o = (count + 2*inflight <= DEPTH_HW-2).
  - imem_addr_o=fetch_pc; on issue, fetch_pc+=4 (wraps mod 2^32).
  - inflight<=imem_req_o.
- Response write: when imem_rvalid_i & ~taken_d_i:
  - skip_hw=0: write hw0=rdata[15:0], then rdata[31:16].
  - skip_hw=1: write only rdata[31:16], then clear skip_hw.
- Pop and write in the same cycle: count_next = count + written - popped. Pointers wrap modulo DEPTH_HW.
- Overflow cannot occur because of the issue rule. An rvalid with inflight=0 is ignored; it is flagged by a simulation assertion.
- A 32-bit instruction that straddles words remains not-valid until its second halfword arrives.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined: adds outputs perf_starve_cnt_o[31:0] and perf_redirect_cnt_o[31:0], both 32-bit, reset 0, wrap on overflow.
  - perf_starve_cnt_o increments each cycle with enable & ~valid & ~taken_d_i.
  - perf_redirect_cnt_o increments each cycle with taken_d_i.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset release, memory returns 0x00a00093 (addi) at address 0 -> req at addr 0x0 in cycle 0; cycle 2: instr_valid_f_o=1, instruction_f_o=0x00a00093.
- Word at 0x0 = {C.NOP 0x0001, C.LI 0x4505}, enable=1, is_compressed_d_i=1 both cycles -> 0x4505 then 0x0001 presented on consecutive cycles, each popping 1 halfword.
- 32-bit instr at 0x2 straddling words 0x0/0x4 -> not valid until word 0x4 written; then instruction_f_o equals the combined instruction.
- taken_d_i=1, redirection_d_i=0x0000_0102 -> imem_addr_o=0x100 same cycle; only rdata[31:16] enqueued; a stale rvalid in the redirect cycle is not enqueued.
- enable=0 for 10 cycles -> requests stop once count+2*inflight > DEPTH_HW-2; count saturates at 8; no data lost after enable=1.
- Assert resetn=0 mid-stream -> outputs clear immediately, without a clock edge; after release the first request is at RESET_PC.
